// File: rtl/pipe_stage_buf_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf_if
//   Valid/ready handshake bundle used between MIPS pipeline stages.
//   The producer drives valid and data. The consumer drives ready.
//   A transfer happens on a rising clock edge when valid && ready.
//
// Signals
//   valid  producer -> consumer  data holds a valid instruction payload
//   ready  consumer -> producer  consumer takes data this cycle
//   data   producer -> consumer  opaque payload (IR, PC8, AO, DR, A3, Res, ...)
//
// Modports
//   master  producer side (drives valid/data, observes ready)
//   slave   consumer side (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_buf_if #(
  parameter int DATA_W = 136
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   Generic inter-stage pipeline register for the MIPS pipeline
//   (F/D, D/E, E/M and M/W). Features:
//     - valid/ready handshake, so a stalled stage applies back-pressure
//     - synchronous flush, for branch and exception redirects
//     - an optional 2-entry skid buffer, so that in_ready comes straight
//       from a flop
//     - a saturating count of stall cycles
//
// Parameters
//   DATA_W  payload width (default is the M/W bundle: 4x32 + 5 + 2 + 1)
//   SKID    1: two entries, in_ready registered
//           0: one entry, in_ready combinational through out_ready
//   BUBBLE  payload shown while the stage is empty (all zero = nop, A3 = 0)
//   CNT_W   width of stall_cnt
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-high reset
//   in_if      slave side of the upstream handshake (in_valid/in_ready/in_data)
//   out_if     master side of the downstream handshake (out_valid/out_ready/out_data)
//   flush      synchronous kill of all held entries
//   stall_cnt  number of cycles with out_valid && !out_ready (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int                DATA_W = 136,
  parameter bit                SKID   = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_stage_buf_if.slave      in_if,
  pipe_stage_buf_if.master     out_if,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt
);

  // State tracks occupancy.
  //   ST_EMPTY  no entries held
  //   ST_FULL1  main register valid
  //   ST_FULL2  main and skid registers valid (only reachable with SKID=1)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;   // output register, drives out_data
  logic [DATA_W-1:0] skid_q, skid_d;   // overflow register, holds the younger entry
  logic              in_ready_q;
  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              retire;

  assign out_valid = (state_q != ST_EMPTY);

  // With the skid buffer, in_ready is a flop, which breaks the ready path
  // between stages. Without it, a stalled stage can still accept when
  // downstream drains in the same cycle.
  assign in_ready = SKID ? in_ready_q : (!out_valid || out_if.ready);

  assign accept = in_if.valid && in_ready;
  assign retire = out_valid && out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_q;

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. This means
    // "hold" is the implicit case, and no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_if.data;
          state_d = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (accept && retire) begin
          main_d = in_if.data;
        end else if (accept) begin
          // Downstream is stalled, so the new entry parks behind main.
          skid_d  = in_if.data;
          state_d = ST_FULL2;
        end else if (retire) begin
          main_d  = BUBBLE;
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        // in_ready is low here, so only a retire can happen.
        if (retire) begin
          main_d  = skid_q;
          skid_d  = BUBBLE;
          state_d = ST_FULL1;
        end
      end
      default: begin
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
        state_d = ST_EMPTY;
      end
    endcase

    // Flush overrides everything and discards any accept in the same cycle.
    if (flush) begin
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
      state_d = ST_EMPTY;
    end
  end

  // State, payload and registered ready.
  // NOTE: the payload registers are reset along with the control state,
  // because out_data must read BUBBLE as soon as reset is asserted. The
  // downstream stage samples it as a nop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples values from before the edge.
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_FULL2);
    end
  end

  // The stall counter ignores flush and is cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_if.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
